mem_stage: RTL and testbench
============================

# mem_stage

Memory-access (MM) stage of the 5-stage RISC-V pipeline. Consumes the EX/MEM pipeline-register outputs (`*_MM`) and runs word loads/stores against a variable-latency data memory through a req/ack handshake. It freezes the upstream EX/MEM register with `stall` while an access is outstanding, and registers the writeback bundle (`*_WB`) for the MEM/WB stage.

## Interface
- `TIMEOUT`, 16: max cycles `dmem_req` is held without `dmem_ack` before the access is aborted (≥2).
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `alu_result_MM` in 32: ALU result; memory address for loads/stores.
- `pc_MM` in 32: instruction PC.
- `R1_data_MM` in 32: store data.
- `R3_addr_MM` in 5: destination register.
- `mem_rw_MM` in 1: 1 = store, 0 = no store.
- `R3_dcntrl_MM` in 2: writeback select. 00 none, 01 ALU, 10 load data, 11 PC+4.
- `opcode_MM` in 6, `flags_MM` in 3: passed through.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32, `dmem_wdata` out 32: memory request.
- `dmem_rdata` in 32, `dmem_ack` in 1: memory response; `dmem_ack` is a 1-cycle pulse.
- `stall` out 1: hold the EX/MEM register (its `enable` = `~stall`).
- `wb_data_WB` out 32, `R3_addr_WB` out 5, `R3_dcntrl_WB` out 2, `pc_WB` out 32, `opcode_WB` out 6, `flags_WB` out 3: registered writeback bundle.
- `mem_err` out 1: sticky error (misaligned or timeout).

## Operation
- `memop` = `mem_rw_MM` OR (`R3_dcntrl_MM` == 10).
- A store takes precedence over a load.
- `misal` = `memop` AND (`alu_result_MM[1:0]` != 0).
- FSM states: IDLE, BUSY.
- **IDLE, no `memop`:**
  - Capture the bundle into `*_WB`.
  - `wb_data_WB` is: `alu_result_MM` for dcntrl 00/01; `pc_MM`+4 (mod 2^32) for dcntrl 11.
  - `stall` = 0.
- **IDLE, `misal`:**
  - No request is issued.
  - Set `mem_err`.
  - Write a bubble to WB (all `*_WB` = 0).
  - `stall` = 0; stay in IDLE.
- **IDLE, aligned `memop`:**
  - `stall` = 1 (combinational).
  - Write a bubble to WB.
  - Latch `dmem_addr` = `alu_result_MM`, `dmem_wdata` = `R1_data_MM`, `dmem_we` = `mem_rw_MM`.
  - Clear the timeout counter; go to BUSY.
- **BUSY:**
  - `dmem_req` = 1; addr, wdata and we are held stable.
  - `stall` = NOT `dmem_ack`.
  - Each cycle without ack: bubble to WB, counter +1.
- **BUSY, `dmem_ack` = 1:**
  - Capture the bundle to WB.
  - For a load, `wb_data_WB` = `dmem_rdata`.
  - For a store, `R3_dcntrl_WB` forced to 00 and `wb_data_WB` = `alu_result_MM`.
  - Go to IDLE. The EX/MEM register advances on the same edge.
- **BUSY, timeout** (counter == `TIMEOUT`−1 and no ack):
  - Bubble to WB, set `mem_err`, `stall` = 0, go to IDLE.
  - `dmem_req` drops next cycle.
  - `dmem_req` is therefore high for exactly `TIMEOUT` cycles. An ack in the last of those cycles counts as success.
- `dmem_ack` in IDLE is ignored.
- `R3_addr_MM` = 0 is passed through unchanged; the register file discards writes to x0.
- `mem_err` clears only on `reset`.

## Timing
- Reset values:
  - State IDLE.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` = 0.
  - Counter 0, `mem_err` = 0.
  - All `*_WB` = 0.
  - `stall` = 0.
- `reset` during BUSY aborts the access: `dmem_req` = 0 the next cycle, no WB write, no error.
- Latency, instruction presented at edge t:
  - Non-memory instruction: WB valid after edge t+1.
  - Memory op with ack in the first BUSY cycle: WB after edge t+2, `stall` high for 1 cycle.
  - Memory op with ack in BUSY cycle k: `stall` high for k cycles, WB after edge t+1+k.
- Back-to-back memory ops: the ack edge loads the next op; it is seen in IDLE the following cycle, giving 1 idle-request cycle between accesses.
- `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` and `*_WB` are registered. `stall` is combinational from state, `*_MM` and `dmem_ack`.

## Test plan
- ALU op: dcntrl 01, alu_result 0x0000_0040, R3 5 → next edge WB data 0x40, R3 5, dcntrl 01, `stall` = 0, `dmem_req` never high.
- Load, 0-wait: addr 0x100, dcntrl 10, ack in the first BUSY cycle with rdata 0xDEAD_BEEF → `stall` 1 cycle, `dmem_req` 1 cycle with we = 0, WB data 0xDEADBEEF at t+2.
- Store, 3-wait: mem_rw 1, addr 0x200, R1 0x1234_5678, ack in the 3rd BUSY cycle → `dmem_we` = 1, addr/wdata stable for 3 cycles, `stall` 3 cycles, WB dcntrl 00, bubbles in between.
- Misaligned load: addr 0x103 → no `dmem_req`, `mem_err` = 1 and stays set, WB bubble, `stall` = 0.
- Timeout with `TIMEOUT` = 4, no ack → `dmem_req` high exactly 4 cycles, `mem_err` = 1, `stall` drops in the 4th cycle, WB bubble.
- Reset in the 2nd BUSY cycle → next cycle IDLE, `dmem_req` = 0, all `*_WB` = 0, `mem_err` = 0; a subsequent ALU op passes normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: word loads/stores over a req/ack data-memory port,
// stalls EX/MEM while an access is outstanding and registers the writeback bundle.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result_MM,
    input  logic [31:0] pc_MM,
    input  logic [31:0] R1_data_MM,
    input  logic [4:0]  R3_addr_MM,
    input  logic        mem_rw_MM,
    input  logic [1:0]  R3_dcntrl_MM,
    input  logic [5:0]  opcode_MM,
    input  logic [2:0]  flags_MM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [31:0] wb_data_WB,
    output logic [4:0]  R3_addr_WB,
    output logic [1:0]  R3_dcntrl_WB,
    output logic [31:0] pc_WB,
    output logic [5:0]  opcode_WB,
    output logic [2:0]  flags_WB,
    output logic        mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d, we_q, we_d, err_q, err_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0]      wb_data_q, wb_data_d, wb_pc_q, wb_pc_d;
    logic [4:0]       wb_r3_q, wb_r3_d;
    logic [1:0]       wb_dc_q, wb_dc_d;
    logic [5:0]       wb_op_q, wb_op_d;
    logic [2:0]       wb_fl_q, wb_fl_d;
    logic             memop, misal;

    assign memop = mem_rw_MM | (R3_dcntrl_MM == 2'b10);
    assign misal = memop & (alu_result_MM[1:0] != 2'b00);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        stall     = 1'b0;
        // Bubble by default; only a completed instruction overrides it.
        wb_data_d = '0;
        wb_pc_d   = '0;
        wb_r3_d   = '0;
        wb_dc_d   = '0;
        wb_op_d   = '0;
        wb_fl_d   = '0;
        case (state_q)
            IDLE: begin
                if (!memop) begin
                    wb_data_d = (R3_dcntrl_MM == 2'b11) ? pc_MM + 32'd4 : alu_result_MM;
                    wb_pc_d   = pc_MM;
                    wb_r3_d   = R3_addr_MM;
                    wb_dc_d   = R3_dcntrl_MM;
                    wb_op_d   = opcode_MM;
                    wb_fl_d   = flags_MM;
                end else if (misal) begin
                    err_d = 1'b1;
                end else begin
                    stall   = 1'b1;
                    req_d   = 1'b1;
                    we_d    = mem_rw_MM;
                    addr_d  = alu_result_MM;
                    wdata_d = R1_data_MM;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    wb_data_d = mem_rw_MM ? alu_result_MM : dmem_rdata;
                    wb_pc_d   = pc_MM;
                    wb_r3_d   = R3_addr_MM;
                    wb_dc_d   = mem_rw_MM ? 2'b00 : R3_dcntrl_MM;
                    wb_op_d   = opcode_MM;
                    wb_fl_d   = flags_MM;
                    req_d     = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            wb_data_q <= '0;
            wb_pc_q   <= '0;
            wb_r3_q   <= '0;
            wb_dc_q   <= '0;
            wb_op_q   <= '0;
            wb_fl_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            wb_data_q <= wb_data_d;
            wb_pc_q   <= wb_pc_d;
            wb_r3_q   <= wb_r3_d;
            wb_dc_q   <= wb_dc_d;
            wb_op_q   <= wb_op_d;
            wb_fl_q   <= wb_fl_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign mem_err      = err_q;
    assign wb_data_WB   = wb_data_q;
    assign pc_WB        = wb_pc_q;
    assign R3_addr_WB   = wb_r3_q;
    assign R3_dcntrl_WB = wb_dc_q;
    assign opcode_WB    = wb_op_q;
    assign flags_WB     = wb_fl_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT = 4): vector table for non-memory ops
// plus hand-written load/store/misaligned/timeout/reset sequences.
module tb_mem_stage;

    logic        clk, reset;
    logic [31:0] alu_result_MM, pc_MM, R1_data_MM;
    logic [4:0]  R3_addr_MM;
    logic        mem_rw_MM;
    logic [1:0]  R3_dcntrl_MM;
    logic [5:0]  opcode_MM;
    logic [2:0]  flags_MM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack, stall;
    logic [31:0] wb_data_WB, pc_WB;
    logic [4:0]  R3_addr_WB;
    logic [1:0]  R3_dcntrl_WB;
    logic [5:0]  opcode_WB;
    logic [2:0]  flags_WB;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .alu_result_MM(alu_result_MM), .pc_MM(pc_MM), .R1_data_MM(R1_data_MM),
        .R3_addr_MM(R3_addr_MM), .mem_rw_MM(mem_rw_MM), .R3_dcntrl_MM(R3_dcntrl_MM),
        .opcode_MM(opcode_MM), .flags_MM(flags_MM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .wb_data_WB(wb_data_WB), .R3_addr_WB(R3_addr_WB),
        .R3_dcntrl_WB(R3_dcntrl_WB), .pc_WB(pc_WB), .opcode_WB(opcode_WB),
        .flags_WB(flags_WB), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  r3;
        logic [1:0]  dc;
        logic [5:0]  op;
        logic [2:0]  fl;
        logic        ack;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [4:0] r3, input logic rw, input logic [1:0] dc);
        alu_result_MM = alu;
        pc_MM         = pc;
        R1_data_MM    = r1;
        R3_addr_MM    = r3;
        mem_rw_MM     = rw;
        R3_dcntrl_MM  = dc;
        opcode_MM     = 6'h03;
        flags_MM      = 3'b010;
    endtask

    task automatic nop();
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        opcode_MM = 6'h0;
        flags_MM  = 3'b0;
    endtask

    task automatic chk_bubble(input string nm);
        chk({nm, "_wbdata"}, wb_data_WB, 32'h0);
        chk({nm, "_wbbits"}, {16'h0, R3_addr_WB, R3_dcntrl_WB, opcode_WB, flags_WB},
            32'h0);
        chk({nm, "_wbpc"}, pc_WB, 32'h0);
    endtask

    initial begin
        int reqcnt;
        vecs[0] = '{32'h0000_0040, 32'h0000_1000, 5'd5,  2'b01, 6'h13, 3'b001, 1'b0, 32'h0000_0040};
        vecs[1] = '{32'h0000_0055, 32'h0000_2000, 5'd9,  2'b11, 6'h1b, 3'b100, 1'b0, 32'h0000_2004};
        vecs[2] = '{32'h0000_0007, 32'hFFFF_FFFC, 5'd1,  2'b11, 6'h2a, 3'b111, 1'b0, 32'h0000_0000};
        vecs[3] = '{32'hABCD_0001, 32'h0000_3000, 5'd0,  2'b00, 6'h3f, 3'b011, 1'b1, 32'hABCD_0001};

        reset = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        nop();
        tick();
        tick();
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_err", {31'h0, mem_err}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk_bubble("rst");
        reset = 1'b0;

        // Non-memory instructions, one cycle each
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i].alu, vecs[i].pc, 32'hFFFF_FFFF, vecs[i].r3, 1'b0, vecs[i].dc);
            opcode_MM = vecs[i].op;
            flags_MM  = vecs[i].fl;
            dmem_ack  = vecs[i].ack;
            #1;
            chk($sformatf("v%0d_stall", i), {31'h0, stall}, 32'h0);
            tick();
            chk($sformatf("v%0d_data", i), wb_data_WB, vecs[i].exp_data);
            chk($sformatf("v%0d_r3", i), {27'h0, R3_addr_WB}, {27'h0, vecs[i].r3});
            chk($sformatf("v%0d_dc", i), {30'h0, R3_dcntrl_WB}, {30'h0, vecs[i].dc});
            chk($sformatf("v%0d_pc", i), pc_WB, vecs[i].pc);
            chk($sformatf("v%0d_opfl", i), {23'h0, opcode_WB, flags_WB}, {23'h0, vecs[i].op, vecs[i].fl});
            chk($sformatf("v%0d_req", i), {31'h0, dmem_req}, 32'h0);
        end
        dmem_ack = 1'b0;

        // Load, ack in first BUSY cycle
        drive(32'h0000_0100, 32'h0000_4000, 32'h5555_5555, 5'd6, 1'b0, 2'b10);
        #1;
        chk("ld_stall0", {31'h0, stall}, 32'h1);
        tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_req", {31'h0, dmem_req}, 32'h1);
        chk("ld_we", {31'h0, dmem_we}, 32'h0);
        chk("ld_addr", dmem_addr, 32'h0000_0100);
        chk("ld_stall1", {31'h0, stall}, 32'h0);
        chk_bubble("ld_b");
        tick();
        dmem_ack = 1'b0;
        nop();
        chk("ld_data", wb_data_WB, 32'hDEAD_BEEF);
        chk("ld_r3", {27'h0, R3_addr_WB}, 32'd6);
        chk("ld_dc", {30'h0, R3_dcntrl_WB}, 32'd2);
        chk("ld_req_off", {31'h0, dmem_req}, 32'h0);

        // Store with ack in the 3rd BUSY cycle
        tick();
        drive(32'h0000_0200, 32'h0000_5000, 32'h1234_5678, 5'd7, 1'b1, 2'b01);
        #1;
        chk("st_stall0", {31'h0, stall}, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 3) dmem_ack = 1'b1;
            #1;
            chk($sformatf("st%0d_req", k), {31'h0, dmem_req}, 32'h1);
            chk($sformatf("st%0d_we", k), {31'h0, dmem_we}, 32'h1);
            chk($sformatf("st%0d_addr", k), dmem_addr, 32'h0000_0200);
            chk($sformatf("st%0d_wdata", k), dmem_wdata, 32'h1234_5678);
            chk($sformatf("st%0d_stall", k), {31'h0, stall}, (k == 3) ? 32'h0 : 32'h1);
            chk_bubble($sformatf("st%0d", k));
        end
        tick();
        dmem_ack = 1'b0;
        nop();
        chk("st_data", wb_data_WB, 32'h0000_0200);
        chk("st_dc", {30'h0, R3_dcntrl_WB}, 32'h0);
        chk("st_r3", {27'h0, R3_addr_WB}, 32'd7);
        chk("st_req_off", {31'h0, dmem_req}, 32'h0);
        chk("st_err", {31'h0, mem_err}, 32'h0);

        // Misaligned load
        tick();
        drive(32'h0000_0103, 32'h0000_6000, 32'h0, 5'd8, 1'b0, 2'b10);
        #1;
        chk("mis_stall", {31'h0, stall}, 32'h0);
        tick();
        nop();
        chk("mis_req", {31'h0, dmem_req}, 32'h0);
        chk("mis_err", {31'h0, mem_err}, 32'h1);
        chk_bubble("mis");
        tick();
        tick();
        chk("mis_sticky", {31'h0, mem_err}, 32'h1);
        chk("mis_req2", {31'h0, dmem_req}, 32'h0);

        // Clear error, then timeout with no ack
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("clr_err", {31'h0, mem_err}, 32'h0);
        drive(32'h0000_0300, 32'h0000_7000, 32'h0, 5'd4, 1'b0, 2'b10);
        #1;
        chk("to_stall0", {31'h0, stall}, 32'h1);
        reqcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dmem_req) reqcnt++;
            if (i < 3) chk($sformatf("to%0d_stall", i), {31'h0, stall}, 32'h1);
            if (i == 3) begin
                chk("to3_stall", {31'h0, stall}, 32'h0);
                nop();
            end
            if (i == 4) begin
                chk("to_err", {31'h0, mem_err}, 32'h1);
                chk_bubble("to");
            end
        end
        chk("to_reqcnt", reqcnt, 32'd4);

        // Reset during the 2nd BUSY cycle
        drive(32'h0000_0400, 32'h0000_8000, 32'h0, 5'd2, 1'b0, 2'b10);
        tick();
        chk("rb1_req", {31'h0, dmem_req}, 32'h1);
        tick();
        chk("rb2_req", {31'h0, dmem_req}, 32'h1);
        reset = 1'b1;
        nop();
        tick();
        reset = 1'b0;
        chk("rb_req", {31'h0, dmem_req}, 32'h0);
        chk("rb_err", {31'h0, mem_err}, 32'h0);
        chk("rb_stall", {31'h0, stall}, 32'h0);
        chk_bubble("rb");
        drive(32'h0000_0099, 32'h0000_9000, 32'h0, 5'd3, 1'b0, 2'b01);
        #1;
        chk("post_stall", {31'h0, stall}, 32'h0);
        tick();
        chk("post_data", wb_data_WB, 32'h0000_0099);
        chk("post_r3", {27'h0, R3_addr_WB}, 32'd3);
        chk("post_req", {31'h0, dmem_req}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
